// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response tagging,
// static branch prediction on returned words, and a small output FIFO toward decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [32:0] branch_out
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        ptr_inc = (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [31:0]     pc_q, pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PtrW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;

    logic [31:0] tag_mem_q    [DEPTH];
    logic [31:0] instr_mem_q  [DEPTH];
    logic [31:0] pc_mem_q     [DEPTH];
    logic        taken_mem_q  [DEPTH];
    logic [31:0] target_mem_q [DEPTH];

    logic [CntW:0] credit_used;
    logic          req_fire, rsp_fire, rsp_drop, push, pop, head_valid;
    logic [31:0]   rsp_pc, imm_b, imm_j, pred_target;
    logic          pred_taken;

    // Credit covers both in-flight requests and buffered instructions.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, out_cnt_q};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CntW + 1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire = !reset && imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_fire && (drop_cnt_q != '0);
    assign push     = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;
    assign rsp_pc   = tag_mem_q[tag_rd_q];

    assign head_valid = !reset && (out_cnt_q != '0);
    assign out_valid  = head_valid && !redirect_valid;
    assign pop        = out_valid && !stall;

    assign instruction = head_valid ? instr_mem_q[out_rd_q] : '0;
    assign pc          = head_valid ? pc_mem_q[out_rd_q] : '0;
    assign branch_out  = head_valid ? {taken_mem_q[out_rd_q], target_mem_q[out_rd_q]} : '0;

    // Backward conditional branches and all jal are predicted taken.
    always_comb begin
        imm_b = {{20{imem_rsp_data[31]}}, imem_rsp_data[7], imem_rsp_data[30:25],
                 imem_rsp_data[11:8], 1'b0};
        imm_j = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                 imem_rsp_data[30:21], 1'b0};
        pred_taken  = 1'b0;
        pred_target = rsp_pc + 32'd4;
        if (imem_rsp_data[6:0] == OpBranch && imem_rsp_data[31]) begin
            pred_taken  = 1'b1;
            pred_target = rsp_pc + imm_b;
        end else if (imem_rsp_data[6:0] == OpJal) begin
            pred_taken  = 1'b1;
            pred_target = rsp_pc + imm_j;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_fire);
        drop_cnt_d    = drop_cnt_q;
        tag_wr_d      = req_fire ? ptr_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d      = rsp_fire ? ptr_inc(tag_rd_q) : tag_rd_q;
        out_wr_d      = out_wr_q;
        out_rd_d      = out_rd_q;
        out_cnt_d     = out_cnt_q;

        if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CntW'(1);
        end

        // Every request still in flight after a flow change returns a stale word.
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            drop_cnt_d = outstanding_d;
        end else if (push && pred_taken) begin
            pc_d       = pred_target;
            drop_cnt_d = outstanding_d;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect_valid) begin
            out_wr_d  = '0;
            out_rd_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (push) out_wr_d = ptr_inc(out_wr_q);
            if (pop)  out_rd_d = ptr_inc(out_rd_q);
            out_cnt_d = out_cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            out_cnt_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            out_wr_q      <= '0;
            out_rd_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            out_cnt_q     <= out_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            out_wr_q      <= out_wr_d;
            out_rd_q      <= out_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem_q[tag_wr_q] <= imem_req_addr;
        end
        if (push) begin
            instr_mem_q[out_wr_q]  <= imem_rsp_data;
            pc_mem_q[out_wr_q]     <= rsp_pc;
            taken_mem_q[out_wr_q]  <= pred_taken;
            target_mem_q[out_wr_q] <= pred_target;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based instruction memory model plus per-scenario checks.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] BeqWord = 32'hFE00_0EE3;
    localparam logic [31:0] JalWord = 32'h1000_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [32:0] branch_out;

    logic        beq_en, jal_en, mem_hold;
    logic [31:0] rsp_addr;
    logic [31:0] mem_q [$];
    logic [31:0] req_q [$];
    logic [96:0] deliv_q [$];
    int          base_req, base_del;
    int          total = 0;
    int          bad   = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .instruction    (instruction),
        .pc             (pc),
        .branch_out     (branch_out)
    );

    always #5 clk = ~clk;

    // Default word is addi x0,x0,addr[11:0] so each delivered word identifies its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (beq_en && a == 32'h10) return BeqWord;
        if (jal_en && a == 32'h20) return JalWord;
        return {a[11:0], 20'h00013};
    endfunction

    // One-cycle in-order memory; mem_hold withholds responses so requests pile up.
    always @(posedge clk) begin
        if (reset) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(mem_q[0]);
                rsp_addr       <= mem_q[0];
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
            if (out_valid && !stall) deliv_q.push_back({pc, instruction, branch_out});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; mem_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base_req = req_q.size();
        base_del = deliv_q.size();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; mem_hold = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if ({instruction, pc, branch_out} !== 97'd0) begin bad++;
            $display("FAIL rst_outputs got=%h/%h/%h want=0", instruction, pc, branch_out); end
        @(negedge clk);
        reset = 1'b0;
        base_req = req_q.size();
        base_del = deliv_q.size();
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++;
            $display("FAIL first_req got=%b/%h want=1/00000000", imem_req_valid, imem_req_addr); end
        total++; if (out_valid !== 1'b0 || branch_out !== 33'd0) begin bad++;
            $display("FAIL post_rst_empty got=%b/%h want=0/0", out_valid, branch_out); end
        @(negedge clk); #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++;
            $display("FAIL second_req got=%b/%h want=1/00000004", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b1 || pc !== 32'h0 || instruction !== 32'h0000_0013) begin bad++;
            $display("FAIL first_out got=%b/%h/%h want=1/00000000/00000013", out_valid, pc, instruction); end
        total++; if (branch_out !== {1'b0, 32'h4}) begin bad++;
            $display("FAIL first_branch_out got=%h want=%h", branch_out, {1'b0, 32'h4}); end
        total++; if (imem_req_valid !== 1'b0) begin bad++;
            $display("FAIL credit_full got=%b want=0", imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] pe;
        logic [96:0] exp_d;
        repeat (30) @(negedge clk);
        #3;
        total++;
        if (req_q.size() < base_req + 8 || deliv_q.size() < base_del + 8) begin
            bad++; $display("FAIL seq_count got=%0d/%0d want=>=8", req_q.size() - base_req,
                            deliv_q.size() - base_del);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            pe = 32'(i * 4);
            exp_d = {pe, {pe[11:0], 20'h00013}, {1'b0, pe + 32'd4}};
            total++; if (req_q[base_req + i] !== pe) begin bad++;
                $display("FAIL seq_req[%0d] got=%h want=%h", i, req_q[base_req + i], pe); end
            total++; if (deliv_q[base_del + i] !== exp_d) begin bad++;
                $display("FAIL seq_out[%0d] got=%h want=%h", i, deliv_q[base_del + i], exp_d); end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int inflight;
        logic [31:0] held;
        do_reset();
        do begin @(negedge clk); #1; n++; end while (!out_valid && n < 10);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_wait got=timeout want=out_valid"); return; end
        stall = 1'b1;
        held = pc;
        total++; if (held !== 32'h0) begin bad++; $display("FAIL stall_head got=%h want=00000000", held); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            inflight = (req_q.size() - base_req) - (deliv_q.size() - base_del);
            total++; if (out_valid !== 1'b1 || pc !== held) begin bad++;
                $display("FAIL stall_hold[%0d] got=%b/%h want=1/%h", i, out_valid, pc, held); end
            total++; if (inflight > 2) begin bad++;
                $display("FAIL stall_credit[%0d] got=%0d want=<=2", i, inflight); end
        end
        total++; if (inflight != 2) begin bad++; $display("FAIL stall_fill got=%0d want=2", inflight); end
        stall = 1'b0;
        repeat (25) @(negedge clk);
        #3;
        for (int i = 0; i < 8; i++) begin
            total++; if (deliv_q[base_del + i][96:65] !== 32'(i * 4)) begin bad++;
                $display("FAIL stall_resume[%0d] got=%h want=%h", i, deliv_q[base_del + i][96:65], 32'(i * 4)); end
        end
    endtask

    task automatic test_beq();
        logic [31:0] exp_req [7];
        logic [31:0] exp_pc  [6];
        logic [96:0] d;
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'hC};
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'hC};
        beq_en = 1'b1; jal_en = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        #3;
        for (int i = 0; i < 7; i++) begin
            total++; if (req_q[base_req + i] !== exp_req[i]) begin bad++;
                $display("FAIL beq_req[%0d] got=%h want=%h", i, req_q[base_req + i], exp_req[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            total++; if (deliv_q[base_del + i][96:65] !== exp_pc[i]) begin bad++;
                $display("FAIL beq_out_pc[%0d] got=%h want=%h", i, deliv_q[base_del + i][96:65], exp_pc[i]); end
        end
        d = deliv_q[base_del + 4];
        total++; if (d[64:0] !== {BeqWord, 1'b1, 32'hC}) begin bad++;
            $display("FAIL beq_pred got=%h want=%h", d[64:0], {BeqWord, 1'b1, 32'hC}); end
    endtask

    task automatic test_jal();
        logic [31:0] pe;
        logic [96:0] d;
        beq_en = 1'b0; jal_en = 1'b1;
        do_reset();
        repeat (30) @(negedge clk);
        #3;
        for (int i = 0; i < 12; i++) begin
            pe = (i < 10) ? 32'(i * 4) : 32'h120 + 32'((i - 10) * 4);
            total++; if (req_q[base_req + i] !== pe) begin bad++;
                $display("FAIL jal_req[%0d] got=%h want=%h", i, req_q[base_req + i], pe); end
        end
        d = deliv_q[base_del + 8];
        total++; if (d !== {32'h20, JalWord, 1'b1, 32'h120}) begin bad++;
            $display("FAIL jal_pred got=%h want=%h", d, {32'h20, JalWord, 1'b1, 32'h120}); end
        d = deliv_q[base_del + 9];
        total++; if (d[96:65] !== 32'h120) begin bad++; $display("FAIL jal_next got=%h want=00000120", d[96:65]); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_req [5];
        logic [31:0] exp_pc  [3];
        exp_req = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
        exp_pc  = '{32'h200, 32'h204, 32'h208};
        beq_en = 1'b0; jal_en = 1'b0;
        do_reset();
        mem_hold = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h200; mem_hold = 1'b0;
        #1;
        total++; if (req_q.size() - base_req != 2) begin bad++;
            $display("FAIL redir_inflight got=%0d want=2", req_q.size() - base_req); end
        total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++;
            $display("FAIL redir_cycle got=%b/%b want=0/0", out_valid, imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (15) @(negedge clk);
        #3;
        for (int i = 0; i < 5; i++) begin
            total++; if (req_q[base_req + i] !== exp_req[i]) begin bad++;
                $display("FAIL redir_req[%0d] got=%h want=%h", i, req_q[base_req + i], exp_req[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (deliv_q[base_del + i][96:65] !== exp_pc[i]) begin bad++;
                $display("FAIL redir_out[%0d] got=%h want=%h", i, deliv_q[base_del + i][96:65], exp_pc[i]); end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        stall = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || pc !== 32'h0) begin bad++;
            $display("FAIL flush_pre got=%b/%h want=1/00000000", out_valid, pc); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h340;
        #1;
        total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin bad++;
            $display("FAIL flush_cycle got=%b/%b want=0/0", out_valid, imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; stall = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h340) begin bad++;
            $display("FAIL flush_after got=%b/%b/%h want=0/1/00000340", out_valid, imem_req_valid, imem_req_addr); end
        repeat (8) @(negedge clk);
        #3;
        total++; if (deliv_q[base_del][96:65] !== 32'h340 || deliv_q[base_del + 1][96:65] !== 32'h344) begin bad++;
            $display("FAIL flush_resume got=%h,%h want=00000340,00000344",
                     deliv_q[base_del][96:65], deliv_q[base_del + 1][96:65]); end
    endtask

    task automatic test_redirect_vs_pred();
        int n = 0;
        int idx;
        beq_en = 1'b1; jal_en = 1'b0;
        do_reset();
        do begin @(negedge clk); #1; n++; end while (!(imem_rsp_valid && rsp_addr == 32'h10) && n < 40);
        total++; if (!(imem_rsp_valid && rsp_addr == 32'h10)) begin bad++;
            $display("FAIL both_wait got=timeout want=rsp_0x10"); return; end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        idx = deliv_q.size();
        total++; if (idx - base_del != 4) begin bad++; $display("FAIL both_before got=%0d want=4", idx - base_del); end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        total++; if (req_q[base_req + 5] !== 32'h300) begin bad++;
            $display("FAIL both_req got=%h want=00000300", req_q[base_req + 5]); end
        total++; if (deliv_q[idx][96:65] !== 32'h300) begin bad++;
            $display("FAIL both_out got=%h want=00000300", deliv_q[idx][96:65]); end
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall = 1'b0; beq_en = 1'b0; jal_en = 1'b0; mem_hold = 1'b0;
        base_req = 0; base_del = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_beq();
        test_jal();
        test_redirect();
        test_redirect_flush();
        test_redirect_vs_pred();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
